rj45_led_serializer: RTL



---
 rtl/rj45_led_pkg.sv | 31 +++
 rtl/rj45_led_serializer_pwm.sv | 35 +++
 rtl/rj45_led_serializer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rj45_led_pkg.sv
// ============================================================================
// rj45_led_pkg : shared mode encodings, FSM states and mode helper
// Revision     : 1.0
// ============================================================================
`default_nettype none

package rj45_led_pkg;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_ANTI   = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_LATCH = 2'b10;

    function automatic logic apply_mode(input logic [1:0] mode, input logic val, input logic phase);
        logic r;
        case (mode)
            MODE_STATIC: r = val;
            MODE_BLINK:  r = val & phase;
            MODE_ANTI:   r = val & ~phase;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rj45_led_serializer_pwm.sv
// ============================================================================
// led_pwm  : free-running 4-bit PWM counter driving the active-high blank line
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_pwm (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] brightness_i,
    output logic       blk_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       blk_q;

    assign cnt_d = cnt_q + 4'd1;

    // blk is registered against the count it will be shown alongside
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
            blk_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            blk_q <= (cnt_d >= brightness_i);
        end
    end

    assign blk_o = blk_q;

endmodule

`default_nettype wire

// File: rtl/rj45_led_serializer.sv
// ============================================================================
// rj45_led_serializer : per-LED mode frame serialiser for the RJ45 LED chain
// Revision            : 1.0
// ============================================================================
`default_nettype none

module rj45_led_serializer
    import rj45_led_pkg::*;
#(
    parameter int N_LEDS    = 8,
    parameter int CLK_DIV   = 4,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [N_LEDS-1:0]     led_vals,
    input  logic [2*N_LEDS-1:0]   led_mode,
    input  logic [3:0]            brightness,
    input  logic                  write_request,
    output logic                  busy,
    output logic                  done,
    output logic                  rj45_led_sck,
    output logic                  rj45_led_sin,
    output logic                  rj45_led_lat,
    output logic                  rj45_led_blk
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int BLK_W = $clog2(BLINK_DIV);

    localparam logic [DIV_W-1:0] C_DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] C_BIT_FIRST  = BIT_W'(N_LEDS - 1);
    localparam logic [BLK_W-1:0] C_BLINK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              half_q, half_d;
    logic [N_LEDS-1:0] frame_q, frame_d;
    logic              pend_q, pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sck_q, sck_d;
    logic              sin_q, sin_d;
    logic              lat_q, lat_d;
    logic [BLK_W-1:0]  blink_cnt_q;
    logic              phase_q;
    logic              auto_q;

    logic              w_wrap;
    logic              w_any_blink;
    logic              w_req;
    logic [N_LEDS-1:0] w_eff;
    logic [N_LEDS-1:0] w_shifted;

    assign w_wrap    = (blink_cnt_q == C_BLINK_LAST);
    assign w_req     = write_request | auto_q;
    assign w_shifted = frame_q << 1;

    always_comb begin
        w_any_blink = 1'b0;
        w_eff       = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (led_mode[2*i +: 2] == MODE_BLINK || led_mode[2*i +: 2] == MODE_ANTI)
                w_any_blink = 1'b1;
            w_eff[i] = apply_mode(led_mode[2*i +: 2], led_vals[i], phase_q);
        end
    end

    // Auto-request is registered so the snapshot sees the already-toggled phase
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            auto_q      <= 1'b0;
        end else begin
            blink_cnt_q <= w_wrap ? '0 : blink_cnt_q + BLK_W'(1);
            if (w_wrap)
                phase_q <= ~phase_q;
            auto_q <= w_wrap & w_any_blink;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        half_d  = half_q;
        frame_d = frame_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sck_d   = sck_q;
        sin_d   = sin_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (w_req || pend_q) begin
                    state_d = ST_SHIFT;
                    frame_d = w_eff;
                    sin_d   = w_eff[N_LEDS-1];
                    bit_d   = C_BIT_FIRST;
                    div_d   = '0;
                    half_d  = 1'b0;
                    busy_d  = 1'b1;
                    sck_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (w_req)
                    pend_d = 1'b1;
                if (div_q == C_DIV_LAST) begin
                    div_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sck_d  = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        sck_d  = 1'b0;
                        if (bit_q == '0) begin
                            state_d = ST_LATCH;
                            lat_d   = 1'b1;
                        end else begin
                            bit_d   = bit_q - BIT_W'(1);
                            frame_d = w_shifted;
                            sin_d   = w_shifted[N_LEDS-1];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (w_req)
                    pend_d = 1'b1;
                if (div_q == C_DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                    lat_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            half_q  <= 1'b0;
            frame_q <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            sin_q   <= 1'b0;
            lat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sck_q   <= sck_d;
            sin_q   <= sin_d;
            lat_q   <= lat_d;
        end
    end

    led_pwm u_pwm (
        .clk          (sys_clk),
        .rst          (reset),
        .brightness_i (brightness),
        .blk_o        (rj45_led_blk)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign rj45_led_sck = sck_q;
    assign rj45_led_sin = sin_q;
    assign rj45_led_lat = lat_q;

endmodule

`default_nettype wire
